// File: rtl/ingress_pkt_parser.sv
// ingress_pkt_parser: parses DA/SA/LEN/payload/PAR frames, buffers them and forwards good packets to egress queues
module ingress_pkt_parser #(
  parameter int MAX_LEN = 16
) (
  input  logic        fast_clk,
  input  logic        reset_b,
  input  logic        data_valid,
  input  logic [7:0]  data,
  output logic        data_stall,
  input  logic [7:0]  port_addr0,
  input  logic [7:0]  port_addr1,
  input  logic [7:0]  port_addr2,
  input  logic [7:0]  port_addr3,
  input  logic [3:0]  q_full,
  output logic        q_wr_en,
  output logic [1:0]  q_wr_port,
  output logic [7:0]  q_wr_data,
  output logic        q_sop,
  output logic        q_eop,
  output logic        pkt_drop,
  output logic [1:0]  drop_code,
  output logic [15:0] fwd_cnt,
  output logic [15:0] drop_cnt
);
  localparam int DEPTH = MAX_LEN + 3;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, SA, LEN, PAY, PAR, FWD} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] len, cnt, xr;
  logic [1:0] port, m_port;
  logic hit, m_hit, acc, last, bad_len, bad_par;
  assign data_stall = state == FWD;
  assign acc = data_valid && !data_stall;
  assign last = 8'(rd_ptr) == len + 8'd2;
  assign bad_len = data == 8'd0 || data > 8'(MAX_LEN);
  assign bad_par = (xr ^ data) != 8'd0;
  assign q_wr_port = port;
  // lowest-index port whose address equals the incoming byte (used only on DA)
  always_comb begin
    m_port = data == port_addr0 ? 2'd0 : data == port_addr1 ? 2'd1 : data == port_addr2 ? 2'd2 : 2'd3;
    m_hit = data == port_addr0 || data == port_addr1 || data == port_addr2 || data == port_addr3;
  end
  // packet buffer: DA, SA, LEN and payload; PAR is checked but never stored
  always_ff @(posedge fast_clk)
    if (acc && state != PAR) mem[wr_ptr] <= data;
  // frame parser, forwarder and counters
  always_ff @(posedge fast_clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len <= '0;
      cnt <= '0;
      xr <= '0;
      port <= '0;
      hit <= 1'b0;
      q_wr_en <= 1'b0;
      q_wr_data <= '0;
      q_sop <= 1'b0;
      q_eop <= 1'b0;
      pkt_drop <= 1'b0;
      drop_code <= '0;
      fwd_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      q_wr_en <= 1'b0;
      q_sop <= 1'b0;
      q_eop <= 1'b0;
      pkt_drop <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          xr <= data;
          port <= m_port;
          hit <= m_hit;
          wr_ptr <= wr_ptr + 1'b1;
          state <= SA;
        end
        SA: if (acc) begin
          xr <= xr ^ data;
          wr_ptr <= wr_ptr + 1'b1;
          state <= LEN;
        end
        LEN: if (acc) begin
          xr <= xr ^ data;
          len <= data;
          cnt <= data;
          wr_ptr <= bad_len ? '0 : wr_ptr + 1'b1;
          pkt_drop <= bad_len;
          drop_code <= bad_len ? 2'b01 : drop_code;
          drop_cnt <= drop_cnt + 16'(bad_len && drop_cnt != 16'hFFFF);
          state <= bad_len ? IDLE : PAY;
        end
        PAY: if (acc) begin
          xr <= xr ^ data;
          wr_ptr <= wr_ptr + 1'b1;
          cnt <= cnt - 8'd1;
          state <= cnt == 8'd1 ? PAR : PAY;
        end
        PAR: if (acc) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          pkt_drop <= bad_par || !hit;
          drop_code <= bad_par ? 2'b11 : !hit ? 2'b10 : drop_code;
          drop_cnt <= drop_cnt + 16'((bad_par || !hit) && drop_cnt != 16'hFFFF);
          state <= bad_par || !hit ? IDLE : FWD;
        end
        FWD: if (!q_full[port]) begin
          q_wr_en <= 1'b1;
          q_wr_data <= mem[rd_ptr];
          q_sop <= rd_ptr == '0;
          q_eop <= last;
          rd_ptr <= rd_ptr + 1'b1;
          fwd_cnt <= fwd_cnt + 16'(last && fwd_cnt != 16'hFFFF);
          state <= last ? IDLE : FWD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ingress_pkt_parser.sv
// tb_ingress_pkt_parser: directed and random frames checked against a packet-level reference model
module tb_ingress_pkt_parser;
  logic fast_clk = 0, reset_b = 0, data_valid = 0;
  logic [7:0] data = 0;
  logic [7:0] addr [4];
  logic [3:0] q_full = 0;
  logic data_stall, q_wr_en, q_sop, q_eop, pkt_drop;
  logic [1:0] q_wr_port, drop_code;
  logic [7:0] q_wr_data;
  logic [15:0] fwd_cnt, drop_cnt;
  int tests = 0, fails = 0, ef = 0, ed = 0, stall_cyc = 0;
  logic [11:0] wq[$];
  logic [1:0] dq[$];
  logic [7:0] pl[$];
  logic done = 0;

  ingress_pkt_parser dut (
    .fast_clk(fast_clk), .reset_b(reset_b), .data_valid(data_valid), .data(data),
    .data_stall(data_stall), .port_addr0(addr[0]), .port_addr1(addr[1]),
    .port_addr2(addr[2]), .port_addr3(addr[3]), .q_full(q_full), .q_wr_en(q_wr_en),
    .q_wr_port(q_wr_port), .q_wr_data(q_wr_data), .q_sop(q_sop), .q_eop(q_eop),
    .pkt_drop(pkt_drop), .drop_code(drop_code), .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
  );

  always #5 fast_clk = ~fast_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // every write and drop pulse must match the next expectation; 12'hFFF / 2'b00 can never be legal
  always @(negedge fast_clk) if (reset_b) begin
    if (data_stall) stall_cyc++;
    if (q_wr_en) check("wr", {q_wr_port, q_sop, q_eop, q_wr_data}, wq.size() != 0 ? wq.pop_front() : 12'hFFF);
    if (pkt_drop) check("drop_code", drop_code, dq.size() != 0 ? dq.pop_front() : 2'b00);
  end

  task automatic put(input logic [7:0] b, input int gap);
    int n = 0;
    data_valid = 0;
    repeat (gap) @(negedge fast_clk);
    data = b;
    data_valid = 1;
    while (data_stall && n < 200) begin
      @(negedge fast_clk);
      n++;
    end
    if (n >= 200) check("stall_timeout", n, 0);
    @(negedge fast_clk);
    data_valid = 0;
  endtask

  // reference model: the whole frame decides its fate, then bytes are driven
  task automatic send_pkt(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] len,
                          input logic [7:0] perr, input int gap);
    logic [7:0] b[$];
    logic [7:0] x;
    int idx;
    b.push_back(da);
    b.push_back(sa);
    b.push_back(len);
    if (len == 0 || len > 16) begin
      dq.push_back(2'b01);
      ed++;
    end else begin
      for (int i = 0; i < int'(len); i++) b.push_back(pl[i]);
      x = 0;
      foreach (b[i]) x ^= b[i];
      b.push_back(x ^ perr);
      idx = -1;
      for (int i = 3; i >= 0; i--) if (addr[i] == da) idx = i;
      if (perr != 0) begin
        dq.push_back(2'b11);
        ed++;
      end else if (idx < 0) begin
        dq.push_back(2'b10);
        ed++;
      end else begin
        for (int i = 0; i < b.size() - 1; i++)
          wq.push_back({2'(idx), i == 0, i == b.size() - 2, b[i]});
        ef++;
      end
    end
    foreach (b[i]) put(b[i], gap < 0 ? $urandom_range(0, 2) : (i > 2 ? gap : 0));
  endtask

  task automatic fill_seq(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'(i + 1));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    repeat (3) @(negedge fast_clk);
    while ((wq.size() != 0 || dq.size() != 0 || data_stall) && n < 3000) begin
      @(negedge fast_clk);
      n++;
    end
    check({tag, "_left"}, wq.size() + dq.size(), 0);
    check({tag, "_fwd"}, fwd_cnt, ef);
    check({tag, "_drop"}, drop_cnt, ed);
  endtask

  task automatic do_reset(input string tag);
    reset_b = 0;
    data_valid = 0;
    repeat (3) @(negedge fast_clk);
    check({tag, "_out"}, {q_wr_en, q_sop, q_eop, pkt_drop, data_stall, q_wr_port, drop_code}, 0);
    check({tag, "_wdata"}, q_wr_data, 0);
    check({tag, "_cnt"}, {fwd_cnt, drop_cnt}, 0);
    wq.delete();
    dq.delete();
    ef = 0;
    ed = 0;
    reset_b = 1;
    @(negedge fast_clk);
  endtask

  initial begin
    int k, n, r;
    logic [7:0] da, len;
    addr = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset("rst0");
    // good packet to port 1, stall exactly 5 cycles
    fill_seq(2);
    stall_cyc = 0;
    send_pkt(8'h22, 8'hAA, 8'h02, 8'h00, 0);
    drain("t1");
    check("t1_stall", stall_cyc, 5);
    // parity error (PAR=00), then unknown DA
    send_pkt(8'h22, 8'hAA, 8'h02, 8'h89, 0);
    send_pkt(8'h55, 8'hAA, 8'h02, 8'h00, 0);
    drain("t2");
    // bad LEN 0 and 17, next byte parses as DA
    send_pkt(8'h11, 8'h01, 8'h00, 8'h00, 0);
    send_pkt(8'h11, 8'h01, 8'h11, 8'h00, 0);
    send_pkt(8'h33, 8'h07, 8'h02, 8'h00, 0);
    drain("t3");
    // back-pressure after 2nd write, back-to-back packet held by stall
    stall_cyc = 0;
    fork
      begin
        send_pkt(8'h22, 8'hAA, 8'h02, 8'h00, 0);
        send_pkt(8'h33, 8'hBB, 8'h02, 8'h00, 0);
      end
      begin
        k = 0;
        n = 0;
        while (k < 2 && n < 200) begin
          @(negedge fast_clk);
          if (q_wr_en) k++;
          n++;
        end
        if (n >= 200) check("t4_wait", n, 0);
        q_full = 4'b0010;
        repeat (3) @(negedge fast_clk);
        q_full = 4'b0000;
      end
    join
    drain("t4");
    check("t4_stall", stall_cyc, 13);
    // bubbles inside payload, then duplicate address routes to lowest port
    stall_cyc = 0;
    send_pkt(8'h22, 8'hAA, 8'h02, 8'h00, 1);
    drain("t5a");
    check("t5_stall", stall_cyc, 5);
    addr[0] = 8'h22;
    send_pkt(8'h22, 8'hAA, 8'h02, 8'h00, 1);
    drain("t5b");
    addr[0] = 8'h11;
    // asynchronous reset mid-payload, then a good packet to port 3
    fill_seq(4);
    put(8'h44, 0);
    put(8'h01, 0);
    put(8'h04, 0);
    put(8'h01, 0);
    put(8'h02, 0);
    #2 reset_b = 0;
    do_reset("t6rst");
    send_pkt(8'h44, 8'h09, 8'h04, 8'h00, 0);
    drain("t6");
    check("t6_fwd1", fwd_cnt, 1);
    // random frames, bubbles and queue back-pressure
    fork
      begin
        for (int p = 0; p < 60; p++) begin
          r = $urandom_range(0, 4);
          da = r < 4 ? addr[r] : 8'($urandom);
          len = $urandom_range(0, 5) == 0 ? 8'($urandom) : 8'($urandom_range(1, 16));
          pl.delete();
          for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
          send_pkt(da, 8'($urandom), len, $urandom_range(0, 6) == 0 ? 8'($urandom_range(1, 255)) : 8'h00, -1);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge fast_clk);
          q_full = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'b0000;
        end
        q_full = 4'b0000;
      end
    join
    drain("rand");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
